sar_adc_ctrl: RTL and testbench

- Digital successive-approximation controller that sits directly upstream of the 10-bit analog DAC macro and drives its D[9:0] code bus.
- The DAC output and the sampled input go to an external analog comparator; the controller reads the comparator's decision back on CMP.
- After START it samples, then binary-searches the input from MSB to LSB, and delivers a WIDTH-bit RESULT with a one-cycle DONE pulse.

---
 rtl/sar_adc_pkg.sv | 20 ++
 rtl/sar_adc_timer.sv | 30 +++
 rtl/sar_adc_ctrl.sv | 136 +++++++++++++
 tb/tb_sar_adc_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_adc_pkg.sv
// Shared types and helpers for the SAR ADC controller.
// Holds the FSM state encoding, default resolution and trial-code helper.
package sar_adc_pkg;

  localparam int SAR_WIDTH = 10;
  localparam int SAR_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_TRIAL  = 2'd2,
    ST_FINISH = 2'd3
  } sar_state_e;

  // Code presented to the DAC while bit idx is under trial.
  function automatic logic [31:0] sar_trial_code(input logic [31:0] acc, input logic [31:0] idx);
    return acc | (32'd1 << idx);
  endfunction

endpackage

// File: rtl/sar_adc_timer.sv
// Loadable down-counter shared by the sample and bit-settle phases.
// o_tc is asserted while enabled and the count has reached zero.
module sar_adc_timer
  import sar_adc_pkg::*;
#(
  parameter int CNT_W = SAR_CNT_W
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = i_en && (r_cnt == '0);

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller driving the DAC code bus, MSB first.
// Optional macro SAR_ADC_CONT_EN adds CONT for back-to-back conversions.
//
// state  | meaning
// IDLE   | waiting for START, DAC_D holds last code
// SAMPLE | track phase, SAMPLE high, DAC_D = 0
// TRIAL  | bit r_bit under trial, CMP decided on the last settle cycle
// FINISH | RESULT loaded, DONE pulses
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int WIDTH         = SAR_WIDTH,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             START,
  input  logic             CMP,
`ifdef SAR_ADC_CONT_EN
  input  logic             CONT,
`endif
  output logic [WIDTH-1:0] DAC_D,
  output logic             SAMPLE,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [SAR_CNT_W-1:0] SAMPLE_LOAD = SAR_CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [SAR_CNT_W-1:0] SETTLE_LOAD = SAR_CNT_W'(SETTLE_CYCLES - 1);

  sar_state_e             r_state, w_state_nxt;
  logic [WIDTH-1:0]       r_acc, w_acc_nxt, w_acc_dec, w_trial, w_dac_nxt;
  logic [IDX_W-1:0]       r_bit, w_bit_nxt;
  logic                   w_load, w_tc, w_tim_en, w_cont;
  logic [SAR_CNT_W-1:0]   w_load_val;

`ifdef SAR_ADC_CONT_EN
  assign w_cont = CONT;
`else
  assign w_cont = 1'b0;
`endif

  assign w_tim_en  = (r_state == ST_SAMPLE) || (r_state == ST_TRIAL);
  assign w_trial   = WIDTH'(sar_trial_code(32'(r_acc), 32'(r_bit)));
  assign w_acc_dec = CMP ? w_trial : r_acc;

  sar_adc_timer #(.CNT_W(SAR_CNT_W)) u_timer (
    .CLK        (CLK),
    .RESETN     (RESETN),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_tim_en),
    .o_tc       (w_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_bit_nxt   = r_bit;
    w_dac_nxt   = DAC_D;
    w_load      = 1'b0;
    w_load_val  = SETTLE_LOAD;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_state_nxt = ST_SAMPLE;
          w_dac_nxt   = '0;
          w_load      = 1'b1;
          w_load_val  = SAMPLE_LOAD;
        end
      end
      ST_SAMPLE: begin
        if (w_tc) begin
          w_state_nxt = ST_TRIAL;
          w_acc_nxt   = '0;
          w_bit_nxt   = IDX_W'(WIDTH - 1);
          w_dac_nxt   = WIDTH'(sar_trial_code(32'd0, 32'(WIDTH - 1)));
          w_load      = 1'b1;
        end
      end
      ST_TRIAL: begin
        if (w_tc) begin
          w_acc_nxt = w_acc_dec;
          if (r_bit == '0) begin
            w_state_nxt = ST_FINISH;
            w_dac_nxt   = w_acc_dec;
          end else begin
            w_bit_nxt = r_bit - 1'b1;
            w_dac_nxt = WIDTH'(sar_trial_code(32'(w_acc_dec), 32'(r_bit - 1'b1)));
            w_load    = 1'b1;
          end
        end
      end
      ST_FINISH: begin
        if (w_cont) begin
          w_state_nxt = ST_SAMPLE;
          w_dac_nxt   = '0;
          w_load      = 1'b1;
          w_load_val  = SAMPLE_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change cleanly on edges.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_bit   <= '0;
      DAC_D   <= '0;
      RESULT  <= '0;
      SAMPLE  <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_bit   <= w_bit_nxt;
      DAC_D   <= w_dac_nxt;
      SAMPLE  <= (w_state_nxt == ST_SAMPLE);
      BUSY    <= (w_state_nxt != ST_IDLE);
      DONE    <= (w_state_nxt == ST_FINISH);
      if (w_state_nxt == ST_FINISH) begin
        RESULT <= w_acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Scoreboard bench for sar_adc_ctrl: ideal comparator, expected RESULT = input code.
// Two instances: default timing, and SAMPLE_CYCLES=1 / SETTLE_CYCLES=3 with noisy CMP.
module tb_sar_adc_ctrl;

  localparam int W    = 10;
  localparam int SA_A = 2;
  localparam int SE_A = 2;
  localparam int SA_B = 1;
  localparam int SE_B = 3;
  localparam int LAT_A = SA_A + W * SE_A;
  localparam int LAT_B = SA_B + W * SE_B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start_a, start_b, cmp_a, cmp_b;
  logic [W-1:0] vin_a, vin_b;
  logic [W-1:0] dac_a, dac_b, result_a, result_b;
  logic         sample_a, sample_b, busy_a, busy_b, done_a, done_b;
`ifdef SAR_ADC_CONT_EN
  logic         cont_a, cont_b;
`endif

  assign cmp_a = (vin_a >= dac_a);

  sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(SA_A), .SETTLE_CYCLES(SE_A)) u_dut_a (
    .CLK    (clk),
    .RESETN (rst_n),
    .START  (start_a),
    .CMP    (cmp_a),
`ifdef SAR_ADC_CONT_EN
    .CONT   (cont_a),
`endif
    .DAC_D  (dac_a),
    .SAMPLE (sample_a),
    .BUSY   (busy_a),
    .DONE   (done_a),
    .RESULT (result_a)
  );

  sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(SA_B), .SETTLE_CYCLES(SE_B)) u_dut_b (
    .CLK    (clk),
    .RESETN (rst_n),
    .START  (start_b),
    .CMP    (cmp_b),
`ifdef SAR_ADC_CONT_EN
    .CONT   (cont_b),
`endif
    .DAC_D  (dac_b),
    .SAMPLE (sample_b),
    .BUSY   (busy_b),
    .DONE   (done_b),
    .RESULT (result_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;
  int done_cnt_a = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [W-1:0] res;
    int           done_cyc;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done_a === 1'b1) begin
      done_cnt_a++;
      if (sb_a.size() == 0) check("a_unexpected_done", 32'd1, 32'd0);
      else begin
        e = sb_a.pop_front();
        check("a_result", 32'(result_a), 32'(e.res));
        check("a_done_cycle", cyc, e.done_cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done_b === 1'b1) begin
      if (sb_b.size() == 0) check("b_unexpected_done", 32'd1, 32'd0);
      else begin
        e = sb_b.pop_front();
        check("b_result", 32'(result_b), 32'(e.res));
        check("b_done_cycle", cyc, e.done_cyc);
      end
    end
  end

  // Comparator for B is only honest in the cycle ending in a decision edge.
  int b_acc = -1000;
  always @(negedge clk) begin
    int c;
    c = cyc - b_acc + 1;
    if (c > SA_B && c <= LAT_B && ((c - SA_B) % SE_B) == 0) cmp_b = (vin_b >= dac_b);
    else cmp_b = 1'($urandom_range(0, 1));
  end

  // Expected DAC code while bit i is under trial: decided upper bits of vin plus bit i.
  function automatic logic [31:0] exp_trial(input int v, input int i);
    return 32'(((v >> (i + 1)) << (i + 1)) | (1 << i));
  endfunction

  task automatic wait_idle_a(input string name);
    int n = 0;
    while (busy_a !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < 200), 32'd1);
  endtask

  task automatic wait_idle_b();
    int n = 0;
    while (busy_b !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b_idle_timeout", 32'(n < 200), 32'd1);
  endtask

  task automatic convert_watch_a(input logic [W-1:0] vin);
    int e;
    int k;
    logic [31:0] exp_dac;
    vin_a   = vin;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    e = cyc;
    sb_a.push_back('{vin, e + LAT_A});
    @(negedge clk);
    start_a = 1'b0;
    for (int c = 1; c <= LAT_A + 2; c++) begin
      check("a_busy", 32'(busy_a), 32'(c <= LAT_A + 1));
      check("a_sample", 32'(sample_a), 32'(c <= SA_A));
      if (c <= SA_A) exp_dac = 32'd0;
      else if (c <= LAT_A) begin
        k = (c - SA_A - 1) / SE_A;
        exp_dac = exp_trial(int'(vin), W - 1 - k);
      end else exp_dac = 32'(vin);
      check("a_dac", 32'(dac_a), exp_dac);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int d0;
    int n;
    logic [W-1:0] v;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    vin_a = '0; vin_b = '0;
`ifdef SAR_ADC_CONT_EN
    cont_a = 1'b0; cont_b = 1'b0;
`endif
    #22;
    check("rst_dac", 32'(dac_a), 32'd0);
    check("rst_result", 32'(result_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_sample", 32'(sample_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    convert_watch_a(10'h2A5);
    convert_watch_a(10'h000);
    convert_watch_a(10'h3FF);

    // START pulses mid-conversion must be dropped, not queued
    d0 = done_cnt_a;
    v = 10'($urandom);
    vin_a = v; start_a = 1'b1;
    @(posedge clk); #1;
    sb_a.push_back('{v, cyc + LAT_A});
    @(negedge clk);
    for (int c = 1; c <= 30; c++) begin
      start_a = (c == 5 || c == 15);
      @(negedge clk);
    end
    start_a = 1'b0;
    check("ign_busy_after", 32'(busy_a), 32'd0);
    check("ign_done_count", done_cnt_a - d0, 1);

    // START held high: restart on the cycle after each return to IDLE
    v = 10'($urandom);
    vin_a = v; start_a = 1'b1;
    @(posedge clk); #1;
    e = cyc;
    sb_a.push_back('{v, e + LAT_A});
    sb_a.push_back('{v, e + LAT_A + 2 + LAT_A});
    while (cyc < e + LAT_A + 1) @(negedge clk);
    check("held_idle_gap", 32'(busy_a), 32'd0);
    @(negedge clk);
    start_a = 1'b0;
    check("held_restart_busy", 32'(busy_a), 32'd1);
    wait_idle_a("a_idle_timeout_held");

    // Asynchronous reset in cycle 10 of a conversion
    vin_a = 10'h2A5; start_a = 1'b1;
    @(posedge clk); #1;
    sb_a.push_back('{10'h2A5, cyc + LAT_A});
    @(negedge clk);
    start_a = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_dac", 32'(dac_a), 32'd0);
    check("arst_result", 32'(result_a), 32'd0);
    check("arst_busy", 32'(busy_a), 32'd0);
    check("arst_sample", 32'(sample_a), 32'd0);
    check("arst_done", 32'(done_a), 32'd0);
    sb_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    convert_watch_a(10'h155);

    for (int t = 0; t < 12; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      convert_watch_a(10'($urandom));
    end

    // Slow-settle instance with CMP noise outside decision cycles
    for (int t = 0; t < 8; t++) begin
      if (t == 0) v = 10'h155;
      else if (t == 1) v = 10'h3FF;
      else if (t == 2) v = 10'h000;
      else v = 10'($urandom);
      vin_b = v; start_b = 1'b1;
      @(posedge clk); #1;
      b_acc = cyc;
      sb_b.push_back('{v, cyc + LAT_B});
      @(negedge clk);
      start_b = 1'b0;
      wait_idle_b();
    end

`ifdef SAR_ADC_CONT_EN
    vin_a = 10'h100; cont_a = 1'b1; start_a = 1'b1;
    @(posedge clk); #1;
    e = cyc;
    sb_a.push_back('{10'h100, e + LAT_A});
    sb_a.push_back('{10'h2FF, e + LAT_A + 1 + LAT_A});
    @(negedge clk);
    start_a = 1'b0;
    for (int c = 1; c <= 2 * (LAT_A + 1) + 1; c++) begin
      check("cont_busy", 32'(busy_a), 32'(c <= 2 * (LAT_A + 1)));
      if (c == LAT_A + 1) vin_a = 10'h2FF;
      if (c == LAT_A + 2) cont_a = 1'b0;
      @(negedge clk);
    end
`endif

    n = 0;
    while ((sb_a.size() != 0 || sb_b.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("sb_a_drained", sb_a.size(), 0);
    check("sb_b_drained", sb_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
